// File: rtl/pwm4sdr_pkg.sv
// Shared definitions for the PWM baseband encoder/decoder pair.
//   pwm_state_e      : pulse sequencing states (IDLE / PULSE / GAP)
//   DEF_*            : default waveform constants
//   SAMPLE_W         : width of signed baseband samples
//   SYMBOL_W         : width of unsigned symbol values
package pwm4sdr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } pwm_state_e;

  localparam int DEF_UNIT_SAMPLES = 4;
  localparam int DEF_GAP_SAMPLES  = 16;
  localparam int DEF_AMPLITUDE    = 1000;
  localparam int DEF_MAX_SYMBOL   = 15;

  localparam int SAMPLE_W = 16;
  localparam int SYMBOL_W = 8;

endpackage

// File: rtl/pwm_phase_counter.sv
// Loadable down-counter that times one waveform phase.
//   clock    : system clock
//   reset_n  : synchronous reset, active low (count clears to 0)
//   load     : load load_val this cycle (wins over dec)
//   load_val : phase length in samples
//   dec      : decrement by one (saturates at 0)
//   last     : count equals 1, i.e. the next decrement ends the phase
module pwm_phase_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             last
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign last = (cnt == WIDTH'(1));

endmodule

// File: rtl/pwm_symbol_encoder.sv
// Turns a symbol stream into a PWM baseband sample stream. Each symbol
// becomes a HIGH phase of (symbol+1)*UNIT_SAMPLES samples at +AMPLITUDE
// followed by GAP_SAMPLES samples at -AMPLITUDE. One sample per sample_en.
//   clock        : system clock
//   reset_n      : synchronous reset, active low
//   sample_en    : sample-rate strobe
//   symbol_in    : unsigned symbol, clamped to MAX_SYMBOL
//   symbol_valid : symbol_in is valid
//   symbol_ready : symbol can be accepted this cycle (combinational)
//   sample_out   : signed output sample (registered)
//   sample_valid : sample_en delayed by one cycle
//   busy         : a pulse (HIGH or GAP phase) is in progress
//   symbol_err   : one-cycle flag after accepting an out-of-range symbol
//
// state    | meaning
// ST_IDLE  | no pulse; emits 0, waits for a symbol
// ST_PULSE | HIGH phase; emits +AMPLITUDE
// ST_GAP   | LOW phase; emits -AMPLITUDE, may chain into the next pulse
import pwm4sdr_pkg::*;

module pwm_symbol_encoder #(
  parameter int UNIT_SAMPLES = DEF_UNIT_SAMPLES,
  parameter int GAP_SAMPLES  = DEF_GAP_SAMPLES,
  parameter int AMPLITUDE    = DEF_AMPLITUDE,
  parameter int MAX_SYMBOL   = DEF_MAX_SYMBOL
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                sample_en,
  input  logic [SYMBOL_W-1:0] symbol_in,
  input  logic                symbol_valid,
  output logic                symbol_ready,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_valid,
  output logic                busy,
  output logic                symbol_err
);

  localparam int CNT_W = $clog2((MAX_SYMBOL + 1) * UNIT_SAMPLES + GAP_SAMPLES) + 1;

  localparam logic [SAMPLE_W-1:0] LEVEL_HIGH = SAMPLE_W'(AMPLITUDE);
  localparam logic [SAMPLE_W-1:0] LEVEL_LOW  = SAMPLE_W'(-AMPLITUDE);
  localparam logic [CNT_W-1:0]    GAP_LEN    = CNT_W'(GAP_SAMPLES);

  if (AMPLITUDE < 0 || AMPLITUDE > 32767) begin : g_amplitude_check
    $error("pwm_symbol_encoder: AMPLITUDE must be within 0..32767");
  end
  if (GAP_SAMPLES < 1) begin : g_gap_check
    $error("pwm_symbol_encoder: GAP_SAMPLES must be at least 1");
  end

  pwm_state_e           state, state_next;
  logic                 cnt_load, cnt_dec, cnt_last;
  logic [CNT_W-1:0]     cnt_load_val;
  logic                 take_sym;
  logic                 sym_clamped;
  logic [SYMBOL_W-1:0]  sym_w;
  logic [CNT_W-1:0]     pulse_len;

  assign sym_clamped = (int'(symbol_in) > MAX_SYMBOL);
  assign sym_w       = sym_clamped ? SYMBOL_W'(MAX_SYMBOL) : symbol_in;
  assign pulse_len   = CNT_W'((int'(sym_w) + 1) * UNIT_SAMPLES);

  // Accepting on the final gap strobe lets the next pulse start on the
  // very next strobe, so back-to-back symbols leave no idle sample.
  assign symbol_ready = (state == ST_IDLE) ||
                        ((state == ST_GAP) && sample_en && cnt_last);
  assign take_sym     = symbol_valid && symbol_ready;
  assign busy         = (state == ST_PULSE) || (state == ST_GAP);

  pwm_phase_counter #(
    .WIDTH(CNT_W)
  ) u_phase_counter (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .last     (cnt_last)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_load_val = pulse_len;
    unique case (state)
      ST_IDLE: begin
        if (take_sym) begin
          state_next = ST_PULSE;
          cnt_load   = 1'b1;
        end
      end
      ST_PULSE: begin
        if (sample_en) begin
          cnt_dec = 1'b1;
          if (cnt_last) begin
            state_next   = ST_GAP;
            cnt_load     = 1'b1;
            cnt_load_val = GAP_LEN;
          end
        end
      end
      ST_GAP: begin
        if (sample_en) begin
          cnt_dec = 1'b1;
          if (cnt_last) begin
            if (take_sym) begin
              state_next = ST_PULSE;
              cnt_load   = 1'b1;
            end else begin
              state_next = ST_IDLE;
            end
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // The emitted level reflects the state before the edge, so an IDLE
  // transfer on a strobe still emits 0 and HIGH starts one strobe later.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sample_out   <= '0;
      sample_valid <= 1'b0;
      symbol_err   <= 1'b0;
    end else begin
      sample_valid <= sample_en;
      symbol_err   <= take_sym && sym_clamped;
      if (sample_en) begin
        unique case (state)
          ST_PULSE: sample_out <= LEVEL_HIGH;
          ST_GAP:   sample_out <= LEVEL_LOW;
          default:  sample_out <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_symbol_encoder.sv
// Self-checking bench for pwm_symbol_encoder. The reference model keeps a
// queue of the samples still owed for accepted symbols: each strobe pops
// one (or yields 0 when empty), each accepted symbol appends its whole
// HIGH and GAP waveform.
module tb_pwm_symbol_encoder;

  logic        clock;
  logic        reset_n;
  logic        sample_en;
  logic [7:0]  symbol_in;
  logic        symbol_valid;
  logic        symbol_ready;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        busy;
  logic        symbol_err;

  pwm_symbol_encoder dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .sample_en    (sample_en),
    .symbol_in    (symbol_in),
    .symbol_valid (symbol_valid),
    .symbol_ready (symbol_ready),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .busy         (busy),
    .symbol_err   (symbol_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam int UNIT = 4;
  localparam int GAP  = 16;
  localparam int AMP  = 1000;
  localparam int MAXS = 15;

  int  errors = 0;
  int  checks = 0;
  int  wave_q[$];
  int  src_q[$];
  int  exp_out = 0;
  bit  exp_valid = 0;
  bit  exp_err = 0;
  bit  exp_ready;
  bit  accepted = 0;
  int  cyc = 0;
  int  en_period = 1;
  int  hi_cnt, lo_cnt, err_cnt, ready_cnt;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  // One clock: check combinational ready, advance model at the edge,
  // check registered outputs on the following falling edge.
  task automatic tick();
    bit take;
    int w;
    #1;
    exp_ready = (wave_q.size() == 0) ||
                (sample_en && wave_q.size() == 1 && wave_q[0] < 0);
    if (reset_n) check("symbol_ready", 32'(symbol_ready), 32'(exp_ready));
    take = reset_n && symbol_valid && exp_ready;
    @(posedge clock);
    if (!reset_n) begin
      wave_q.delete();
      exp_out   = 0;
      exp_valid = 0;
      exp_err   = 0;
    end else begin
      exp_valid = sample_en;
      exp_err   = take && (int'(symbol_in) > MAXS);
      if (sample_en) begin
        if (wave_q.size() > 0) exp_out = wave_q.pop_front();
        else exp_out = 0;
      end
      if (take) begin
        w = (int'(symbol_in) > MAXS) ? MAXS : int'(symbol_in);
        repeat ((w + 1) * UNIT) wave_q.push_back(AMP);
        repeat (GAP) wave_q.push_back(-AMP);
      end
    end
    accepted = take;
    @(negedge clock);
    cyc++;
    check("sample_out",   32'($signed(sample_out)), exp_out);
    check("sample_valid", 32'(sample_valid), 32'(exp_valid));
    check("busy",         32'(busy), 32'(wave_q.size() != 0));
    check("symbol_err",   32'(symbol_err), 32'(exp_err));
    if (sample_valid && $signed(sample_out) == 16'sd1000) hi_cnt++;
    if (sample_valid && $signed(sample_out) == -16'sd1000) lo_cnt++;
    if (symbol_err) err_cnt++;
    if (take) ready_cnt++;
  endtask

  task automatic clear_counts();
    hi_cnt = 0; lo_cnt = 0; err_cnt = 0; ready_cnt = 0;
  endtask

  // Feed src_q to the DUT (source holds each symbol until accepted) and
  // run until the model has emitted everything, within a cycle budget.
  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (src_q.size() == 0 && wave_q.size() == 0 && i > 0) break;
      sample_en    = ((cyc % en_period) == 0);
      symbol_valid = (src_q.size() > 0);
      symbol_in    = (src_q.size() > 0) ? 8'(src_q[0]) : 8'd0;
      tick();
      if (accepted) void'(src_q.pop_front());
    end
    symbol_valid = 1'b0;
    check("drain_done", 32'(src_q.size() + wave_q.size()), 0);
  endtask

  initial begin
    reset_n = 1'b0; sample_en = 1'b1; symbol_in = 8'd5; symbol_valid = 1'b1;
    clear_counts();

    // Reset with strobes and a valid symbol present.
    tick(); tick();
    check("reset_ready", 32'(symbol_ready), 1);
    reset_n = 1'b1; symbol_valid = 1'b0;
    tick(); tick();

    // Single symbol 3.
    clear_counts();
    en_period = 1;
    src_q = '{3};
    drain(200);
    check("t2_high", hi_cnt, 16);
    check("t2_gap",  lo_cnt, 16);
    tick();

    // Back-to-back 0 then 15.
    clear_counts();
    src_q = '{0, 15};
    drain(300);
    check("t3_high", hi_cnt, 4 + 64);
    check("t3_gap",  lo_cnt, 32);

    // Clamped symbol 20.
    clear_counts();
    src_q = '{20};
    drain(200);
    check("t4_err_cycles", err_cnt, 1);
    check("t4_high", hi_cnt, 64);
    check("t4_gap",  lo_cnt, 16);

    // Strobe every third cycle, symbol 1.
    clear_counts();
    en_period = 3;
    src_q = '{1};
    drain(300);
    check("t5_high", hi_cnt, 8);
    check("t5_gap",  lo_cnt, 16);
    en_period = 1;

    // Reset during the 5th HIGH sample of symbol 7, then symbol 2.
    clear_counts();
    sample_en = 1'b1; symbol_in = 8'd7; symbol_valid = 1'b1;
    tick();
    check("t6_accept", 32'(accepted), 1);
    symbol_valid = 1'b0;
    repeat (4) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("t6_busy_after_reset", 32'(busy), 0);
    check("t6_out_after_reset", 32'($signed(sample_out)), 0);
    clear_counts();
    src_q = '{2};
    drain(200);
    check("t6_high", hi_cnt, 12);

    // Randomized traffic.
    symbol_valid = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      sample_en = ($urandom_range(0, 9) < 6);
      if (!symbol_valid || accepted) begin
        symbol_valid = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 7) == 0) symbol_in = 8'($urandom_range(16, 255));
        else symbol_in = 8'($urandom_range(0, 15));
      end
      reset_n = ($urandom_range(0, 399) != 0);
      tick();
    end
    reset_n = 1'b1;
    symbol_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
